// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-Stream frame generator.
package axis_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP
   } state_t;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_LEN_W  = 8;
   localparam int unsigned DEF_GAP_W  = 4;

   localparam logic [7:0] LFSR_SEED = 8'h01;
   // Stages 8,6,5,4 of x^8+x^6+x^5+x^4+1 map to register bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/axis_lfsr.sv
// 8-bit Fibonacci LFSR payload source; only built with AXIS_FRAME_GEN_LFSR_EN.
`ifdef AXIS_FRAME_GEN_LFSR_EN
module axis_lfsr
   import axis_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       step,
   output logic [7:0] q
);

   always_ff @(posedge clk) begin
      if (rst || load) begin
         q <= LFSR_SEED;
      end else if (step) begin
         q <= lfsr_step(q);
      end
   end

endmodule
`endif

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame generator: runs of fixed-length frames separated by idle gaps.
// Define AXIS_FRAME_GEN_LFSR_EN to source the payload from axis_lfsr instead of a counter.
module axis_frame_gen
   import axis_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned LEN_W  = DEF_LEN_W,
   parameter int unsigned GAP_W  = DEF_GAP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  frame_len,
   input  logic [GAP_W-1:0]  gap,
   input  logic [LEN_W-1:0]  num_frames,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  frame_cnt
);

   state_t            state;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  nf_q;
   logic [LEN_W-1:0]  beat_cnt;
   logic [GAP_W-1:0]  gap_q;
   logic [GAP_W-1:0]  gap_cnt;
   logic              accept;
   logic              xfer;
   logic              beat_last;
   logic              run_end;
   logic [LEN_W-1:0]  len_eff;
   logic [LEN_W-1:0]  frame_nxt;
   logic [DATA_W-1:0] data_first;
   logic [DATA_W-1:0] data_nxt;

   // A start landing in the done cycle is dropped even though busy is already low
   assign accept    = start && (state == ST_IDLE) && !done;
   assign xfer      = m_valid && m_ready;
   assign len_eff   = (frame_len == '0) ? LEN_W'(1) : frame_len;
   assign beat_last = (beat_cnt == len_q - LEN_W'(1));
   assign frame_nxt = frame_cnt + LEN_W'(1);
   assign run_end   = (nf_q != '0) && (frame_nxt == nf_q);

`ifdef AXIS_FRAME_GEN_LFSR_EN
   logic [7:0] lfsr_q;

   axis_lfsr u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .step (xfer),
      .q    (lfsr_q)
   );

   assign data_first = DATA_W'(LFSR_SEED);
   assign data_nxt   = DATA_W'(lfsr_step(lfsr_q));
`else
   assign data_first = '0;
   assign data_nxt   = m_data + DATA_W'(1);
`endif

   // Frame sequencing FSM with registered stream outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         m_data    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         frame_cnt <= '0;
         len_q     <= LEN_W'(1);
         nf_q      <= '0;
         gap_q     <= '0;
         gap_cnt   <= '0;
         beat_cnt  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  len_q     <= len_eff;
                  gap_q     <= gap;
                  nf_q      <= num_frames;
                  frame_cnt <= '0;
                  beat_cnt  <= '0;
                  m_data    <= data_first;
                  m_valid   <= 1'b1;
                  m_last    <= (len_eff == LEN_W'(1));
                  busy      <= 1'b1;
                  state     <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (xfer) begin
                  m_data <= data_nxt;
                  if (beat_last) begin
                     frame_cnt <= frame_nxt;
                     beat_cnt  <= '0;
                     if (run_end) begin
                        state   <= ST_IDLE;
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                     end else if (gap_q != '0) begin
                        state   <= ST_GAP;
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        gap_cnt <= gap_q - GAP_W'(1);
                     end else begin
                        m_last <= (len_q == LEN_W'(1));
                     end
                  end else begin
                     beat_cnt <= beat_cnt + LEN_W'(1);
                     m_last   <= ((beat_cnt + LEN_W'(1)) == (len_q - LEN_W'(1)));
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0) begin
                  state   <= ST_SEND;
                  m_valid <= 1'b1;
                  m_last  <= (len_q == LEN_W'(1));
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Self-checking bench for axis_frame_gen: beat-queue model plus directed scenarios.
`timescale 1ns/1ps
module tb_axis_frame_gen;

   localparam int unsigned DW = 8;
   localparam int unsigned LW = 8;
   localparam int unsigned GW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [LW-1:0] frame_len = '0;
   logic [GW-1:0] gap = '0;
   logic [LW-1:0] num_frames = '0;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic          m_last;
   logic          busy;
   logic          done;
   logic [LW-1:0] frame_cnt;

   always #5 clk = ~clk;

   axis_frame_gen #(.DATA_W(DW), .LEN_W(LW), .GAP_W(GW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .frame_len  (frame_len),
      .gap        (gap),
      .num_frames (num_frames),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .busy       (busy),
      .done       (done),
      .frame_cnt  (frame_cnt)
   );

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] exp_data[$];
   bit            exp_last[$];
   logic [DW-1:0] got_data[$];
   bit            got_last[$];

   bit            model_on = 1'b0;
   bit            done_due = 1'b0;
   bit            exp_done_now = 1'b0;
   bit            gap_track = 1'b0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;
   logic [DW-1:0] pop_d;
   bit            pop_l;
   int            exp_gap = 0;
   int            low_cnt = 0;
   int            last_gap = -1;
   int            frames_done = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

`ifdef AXIS_FRAME_GEN_LFSR_EN
   // Shift left, feedback is the XOR of stages 8,6,5,4
   function automatic logic [7:0] lfsr_model(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction
`endif

   // Expand a run into the exact sequence of beats the stream must carry
   task automatic plan_run(input int len, input int g, input int nf);
      int l;
      logic [DW-1:0] v;
      l = (len == 0) ? 1 : len;
`ifdef AXIS_FRAME_GEN_LFSR_EN
      v = 8'h01;
`else
      v = '0;
`endif
      exp_data.delete();
      exp_last.delete();
      got_data.delete();
      got_last.delete();
      frames_done = 0;
      done_due = 1'b0;
      gap_track = 1'b0;
      prev_stall = 1'b0;
      exp_gap = g;
      last_gap = -1;
      for (int f = 0; f < nf; f++) begin
         for (int b = 0; b < l; b++) begin
            exp_data.push_back(v);
            exp_last.push_back(b == l - 1);
`ifdef AXIS_FRAME_GEN_LFSR_EN
            v = lfsr_model(v);
`else
            v = v + DW'(1);
`endif
         end
      end
   endtask

   task automatic launch(input int len, input int g, input int nf);
      plan_run(len, g, nf);
      @(posedge clk); #1;
      frame_len = LW'(len);
      gap = GW'(g);
      num_frames = LW'(nf);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      model_on = 1'b1;
   endtask

   task automatic wait_end(input int budget);
      int k;
      k = 0;
      while (model_on && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      if (model_on) begin
         checks++;
         failures++;
         $display("FAIL run_timeout: %0d beats still pending after %0d cycles", exp_data.size(), budget);
         model_on = 1'b0;
      end
   endtask

   task automatic wait_beat(input logic [DW-1:0] v, input int budget);
      int k;
      k = 0;
      while (!(m_valid && m_data == v) && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      checks++;
      if (!(m_valid && m_data == v)) begin
         failures++;
         $display("FAIL wait_beat: data 0x%0h never presented, last seen 0x%0h", v, m_data);
      end
   endtask

   // Compare process: every cycle of an active run against the planned beat queue
   always @(negedge clk) begin
      if (model_on) begin
         exp_done_now = done_due;
         done_due = 1'b0;
         chk("done", 32'(done), 32'(exp_done_now));
         chk("busy", 32'(busy), 32'(exp_data.size() != 0));
         chk("frame_cnt", 32'(frame_cnt), 32'(frames_done));
         if (prev_stall)
            chk("stall_hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, prev_last, prev_data}));
         if (gap_track) begin
            if (!m_valid) begin
               low_cnt++;
            end else begin
               chk("gap_len", 32'(low_cnt), 32'(exp_gap));
               last_gap = low_cnt;
               gap_track = 1'b0;
            end
         end
         if (exp_data.size() == 0) begin
            chk("valid_after_run", 32'(m_valid), 32'(0));
         end else if (m_valid && m_ready) begin
            pop_d = exp_data.pop_front();
            pop_l = exp_last.pop_front();
            chk("beat", 32'({m_last, m_data}), 32'({pop_l, pop_d}));
            got_data.push_back(m_data);
            got_last.push_back(m_last);
            if (pop_l) begin
               frames_done++;
               if (exp_data.size() == 0) begin
                  done_due = 1'b1;
               end else begin
                  gap_track = 1'b1;
                  low_cnt = 0;
               end
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data = m_data;
         prev_last = m_last;
         if (exp_done_now) model_on = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", 32'({m_valid, m_last, busy, done, frame_cnt, m_data}), 32'(0));
      rst = 1'b0;
      @(posedge clk); #1;

`ifdef AXIS_FRAME_GEN_LFSR_EN
      // LFSR payload, with a start pulse while busy that must be ignored
      launch(4, 0, 1);
      @(posedge clk); #1;
      start = 1'b1; frame_len = LW'(2); num_frames = LW'(3);
      @(posedge clk); #1;
      start = 1'b0;
      wait_end(50);
      chk("lfsr_count", 32'(got_data.size()), 32'(4));
      if (got_data.size() == 4) begin
         chk("lfsr_b0", 32'(got_data[0]), 32'(8'h01));
         chk("lfsr_b1", 32'(got_data[1]), 32'(8'h02));
         chk("lfsr_b2", 32'(got_data[2]), 32'(8'h04));
         chk("lfsr_b3", 32'({got_last[3], got_data[3]}), 32'({1'b1, 8'h08}));
      end
      chk("lfsr_frames", 32'(frame_cnt), 32'(1));
`else
      // Back-to-back frames; inputs change and start pulses mid-run
      m_ready = 1'b1;
      launch(8, 0, 2);
      @(posedge clk); #1;
      start = 1'b1; frame_len = LW'(3); gap = GW'(5); num_frames = LW'(1);
      @(posedge clk); #1;
      start = 1'b0;
      wait_end(100);
      chk("b2b_count", 32'(got_data.size()), 32'(16));
      if (got_data.size() == 16) begin
         chk("b2b_last7", 32'({got_last[7], got_data[7]}), 32'({1'b1, 8'd7}));
         chk("b2b_beat8", 32'({got_last[8], got_data[8]}), 32'({1'b0, 8'd8}));
         chk("b2b_last15", 32'({got_last[15], got_data[15]}), 32'({1'b1, 8'd15}));
      end
      chk("b2b_no_bubble", 32'(last_gap), 32'(0));
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_frame_cnt_hold", 32'(frame_cnt), 32'(2));
`endif

      // Start presented in the done cycle must be dropped
      launch(2, 0, 1);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      chk("done_pulse_seen", 32'(seen), 32'(1));
      start = 1'b1; frame_len = LW'(4); num_frames = LW'(1);
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_on_done_ignored", 32'({m_valid, busy}), 32'(0));
      repeat (2) @(posedge clk);
      #1;
      chk("start_on_done_idle", 32'({m_valid, busy}), 32'(0));

      // Inter-frame gap of 3
      launch(4, 3, 2);
      wait_end(100);
      chk("gap3_count", 32'(got_data.size()), 32'(8));
      chk("gap3_len", 32'(last_gap), 32'(3));

`ifndef AXIS_FRAME_GEN_LFSR_EN
      // Backpressure stall of 5 cycles at beat 3
      launch(8, 0, 1);
      wait_beat(DW'(3), 20);
      m_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("stall_data", 32'({m_valid, m_data}), 32'({1'b1, 8'd3}));
      m_ready = 1'b1;
      wait_end(50);
      chk("stall_count", 32'(got_data.size()), 32'(8));
      if (got_data.size() == 8)
         chk("stall_seq", 32'({got_data[2], got_data[3], got_data[4]}), 32'({8'd2, 8'd3, 8'd4}));
`endif

      // frame_len=0 behaves as single-beat frames
      launch(0, 0, 3);
      wait_end(50);
      chk("len0_count", 32'(got_data.size()), 32'(3));
      if (got_data.size() == 3)
         chk("len0_lasts", 32'({got_last[0], got_last[1], got_last[2]}), 32'(3'b111));
      chk("len0_frame_cnt", 32'(frame_cnt), 32'(3));

      // Irregular backpressure with a one-cycle gap
      launch(3, 1, 2);
      for (int k = 0; k < 200 && model_on; k++) begin
         @(posedge clk); #1;
         m_ready = (k % 3 != 1);
      end
      m_ready = 1'b1;
      wait_end(20);
      chk("bp_count", 32'(got_data.size()), 32'(6));

`ifndef AXIS_FRAME_GEN_LFSR_EN
      // Reset at beat 5 of an 8-beat frame, then restart
      launch(8, 0, 1);
      wait_beat(DW'(5), 20);
      rst = 1'b1;
      model_on = 1'b0;
      @(posedge clk); #1;
      chk("midrst_state", 32'({m_valid, m_last, busy, done, frame_cnt}), 32'(0));
      rst = 1'b0;
      launch(8, 0, 1);
      chk("restart_first", 32'({m_valid, m_data, frame_cnt}), 32'({1'b1, 8'd0, 8'd0}));
      wait_end(50);
      chk("restart_count", 32'(got_data.size()), 32'(8));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_frame_gen.md
AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits.
REQ-002 Parameter LEN_W, default 8, width of the frame-length and frame-count fields.
REQ-003 Parameter GAP_W, default 4, width of the inter-frame-gap field.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  one-cycle request to begin a run; ignored while busy=1.
REQ-007 frame_len  input  LEN_W  beats per frame; 0 is treated as 1.
REQ-008 gap  input  GAP_W  idle cycles between frames.
REQ-009 num_frames  input  LEN_W  frames per run; 0 means run continuously until rst.
REQ-010 m_data  output  DATA_W  stream payload.
REQ-011 m_valid  output  1  payload valid.
REQ-012 m_ready  input  1  downstream accepts the beat.
REQ-013 m_last  output  1  marks the final beat of a frame.
REQ-014 busy  output  1  high from the accepted start until the run completes.
REQ-015 done  output  1  one-cycle pulse when the final frame of a run is accepted.
REQ-016 frame_cnt  output  LEN_W  number of frames completed in the current run.

Function
REQ-017 A beat shall transfer only in a cycle where m_valid=1 and m_ready=1.
REQ-018 FSM states: IDLE, SEND, GAP.
- IDLE->SEND on start.
- SEND->GAP on last-beat handshake when gap>0 and more frames remain.
- SEND->SEND on last-beat handshake when gap=0 and more frames remain.
- GAP->SEND after exactly gap cycles.
- SEND->IDLE on last-beat handshake of the final frame.
REQ-019 frame_len, gap and num_frames shall be latched when start is accepted; input changes during a run shall have no effect.
REQ-020 m_valid shall rise in the cycle after start is sampled, giving a latency of 1 cycle.
REQ-021 Once m_valid=1, m_data and m_last shall hold stable, and m_valid shall stay high, until the handshake completes.
REQ-022 m_valid, m_data and m_last shall be driven from registers, with no combinational path from m_ready.
REQ-023 The beat counter shall run 0..len-1 per frame; m_last=1 exactly when the counter equals len-1.
- len=1 gives m_last=1 on every beat.
REQ-024 With gap=G>0, m_valid shall be low for exactly G cycles between the last-beat handshake and the next first beat.
REQ-025 With gap=0, frames shall be sent back-to-back, with m_valid held high across the frame boundary.
REQ-026 The data source (counter or LFSR) shall advance only on a handshake and shall carry across frame boundaries.
- Counter mode: starts at 0 on start and wraps from 2^DATA_W-1 to 0.
REQ-027 frame_cnt shall clear on start, increment on each last-beat handshake, and hold its value after done.
- In continuous mode it wraps modulo 2^LEN_W.
REQ-028 done shall pulse in the cycle after the final last-beat handshake, the same cycle busy falls.
REQ-029 If m_ready stays low indefinitely, the block shall stall in SEND holding its beat, with no timeout.
REQ-030 A start that coincides with the done cycle shall be ignored; start is accepted only when busy=0.

Reset
REQ-031 Reset shall drive m_valid=0, m_last=0, m_data=0, busy=0, done=0, frame_cnt=0 and state IDLE.
REQ-032 Reset shall reload the data counter with 0 and the LFSR seed with 8'h01.
REQ-033 Reset asserted mid-frame shall deassert m_valid on the next edge and abandon the frame without emitting m_last.

Configuration
REQ-034 With AXIS_FRAME_GEN_LFSR_EN defined, m_data shall come from a Fibonacci LFSR.
- Polynomial x^8+x^6+x^5+x^4+1, seed 8'h01.
- The LFSR is reseeded on start and advances one step per handshake.
REQ-035 Without AXIS_FRAME_GEN_LFSR_EN, m_data shall be the incrementing counter, and no LFSR logic shall be synthesized.

Structure
REQ-036 Shared package axis_pkg shall hold the FSM state typedef, the LFSR seed, the tap constants and the default widths.
REQ-037 The LFSR shall be a sub-module named axis_lfsr, with ports clk, rst, load, step and q, instantiated only under the macro.

Verification
REQ-038 Back-to-back frames, no backpressure, counter mode.
- Stimulus: m_ready=1, len=8, gap=0, num_frames=2.
- Required: data 0..15 with no bubbles; m_last on data 7 and data 15; done one cycle after the last beat; frame_cnt=2.
REQ-039 Inter-frame gap.
- Stimulus: m_ready=1, len=4, gap=3, num_frames=2.
- Required: m_valid low for exactly 3 cycles between data 3 and data 4.
REQ-040 Backpressure stall.
- Stimulus: len=8; m_ready dropped for 5 cycles at beat 3.
- Required: m_data=3 and m_valid=1 held stable for the full stall; no beat lost or duplicated.
REQ-041 Boundary lengths.
- Stimulus: frame_len=0, num_frames=3.
- Required: three single-beat frames, each with m_last=1; frame_cnt=3.
REQ-042 Reset mid-frame, then restart.
- Stimulus: rst at beat 5 of an 8-beat frame, then a new start.
- Required: m_valid=0 on the next edge; the restarted frame begins at data 0 with frame_cnt=0.
REQ-043 LFSR mode.
- Stimulus: AXIS_FRAME_GEN_LFSR_EN defined, len=4, m_ready=1.
- Required: first four beats 01, 02, 04, 08 (hex); a start arriving while busy is ignored.
